// File: rtl/adder4_pkg.sv
// Shared types and widths for the 4-bit-adder result accumulator.
package adder4_pkg;
  localparam int SAMPLE_W = 5;
  localparam int COUNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/adder4_accum_cnt.sv
// Batch sample counter: load-1, increment, sync clear and a terminal-count flag
// that is true when the next increment completes the batch.
module adder4_accum_cnt
  import adder4_pkg::*;
#(
  parameter int N_SAMPLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic               i_inc,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_tc
);

  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= COUNT_W'(1);
    end else if (i_inc) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == COUNT_W'(N_SAMPLES - 1));

endmodule

// File: rtl/adder4_accum.sv
// Accumulates N_SAMPLES 5-bit adder results {cout,sum} per batch with a
// valid/ready handshake on both sides and a sticky overflow flag.
module adder4_accum
  import adder4_pkg::*;
#(
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         sum,
  input  logic               cout,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               clear,
  output logic [ACC_W-1:0]   acc,
  output logic [COUNT_W-1:0] count,
  output logic               ovf,
  output logic               out_valid,
  input  logic               out_ready
);

  state_e              r_state;
  state_e              w_state_next;
  logic [ACC_W-1:0]    r_acc;
  logic                r_ovf;
  logic [SAMPLE_W-1:0] w_sample;
  logic [ACC_W:0]      w_sum_full;
  logic                w_xfer;
  logic                w_first;
  logic                w_inc;
  logic                w_release;
  logic                w_tc;

  assign w_sample   = {cout, sum};
  assign in_ready   = (r_state != DONE);
  assign out_valid  = (r_state == DONE);
  assign w_xfer     = in_valid && in_ready;
  assign w_first    = w_xfer && (r_state == IDLE);
  assign w_inc      = w_xfer && (r_state == ACCUM);
  assign w_release  = out_ready && (r_state == DONE);
  assign w_sum_full = {1'b0, r_acc} + (ACC_W + 1)'(w_sample);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_xfer) w_state_next = (N_SAMPLES == 1) ? DONE : ACCUM;
        ACCUM:   if (w_xfer && w_tc) w_state_next = DONE;
        DONE:    if (out_ready) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // acc/ovf survive the return to IDLE; only a first transfer reloads them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (clear) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_first) begin
      r_acc <= ACC_W'(w_sample);
      r_ovf <= 1'b0;
    end else if (w_inc) begin
      r_acc <= w_sum_full[ACC_W-1:0];
      r_ovf <= r_ovf | w_sum_full[ACC_W];
    end
  end

  adder4_accum_cnt #(
    .N_SAMPLES(N_SAMPLES)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (clear || w_release),
    .i_load (w_first),
    .i_inc  (w_inc),
    .o_count(count),
    .o_tc   (w_tc)
  );

  assign acc = r_acc;
  assign ovf = r_ovf;

endmodule

// File: doc/adder4_accum.md
ADDER4_ACCUM -- requirements
Module: adder4_accum

Interface
REQ-001 The parameter list SHALL be (name, default, meaning):
- N_SAMPLES, 4, sums accumulated per result; legal range 1..15.
- ACC_W, 8, accumulator width; legal range 5..16.
REQ-002 The ports SHALL be (name, direction, width, meaning), clock and reset first:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- sum, in, 4, adder result bits s3..s0.
- cout, in, 1, adder carry-out c4.
- in_valid, in, 1, sum/cout hold a valid sample.
- in_ready, out, 1, block accepts a sample this cycle.
- clear, in, 1, synchronous abort/clear.
- acc, out, ACC_W, accumulated total.
- count, out, 4, samples accepted in the current batch.
- ovf, out, 1, sticky accumulator overflow for the current batch.
- out_valid, out, 1, acc is a final result.
- out_ready, in, 1, consumer takes the result.
REQ-003 One clock, clk; reset rst SHALL be asynchronous and active-high.

Function
REQ-004 The sample value SHALL be v = {cout, sum}: 5-bit unsigned, range 0..31, zero-extended to ACC_W.
REQ-005 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; data presented with in_valid=0 SHALL be ignored.
REQ-006 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-007 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DONE.
REQ-008 IDLE, on a transfer, SHALL load acc<=v, count<=1 and ovf<=0, then go to DONE if N_SAMPLES==1, else to ACCUM.
REQ-009 ACCUM, on a transfer, SHALL set acc<=(acc+v) mod 2^ACC_W and count<=count+1.
REQ-010 In ACCUM, ovf SHALL be set when the ACC_W-bit addition carries out, and SHALL hold until the next batch starts.
REQ-011 ACCUM SHALL go to DONE on the transfer that makes count==N_SAMPLES.
REQ-012 ACCUM without a transfer SHALL hold all state; idle gaps between samples are legal.
REQ-013 out_valid SHALL be 1 exactly while in DONE: it asserts on the cycle after the final transfer, so latency is 1 cycle after the Nth sample.
REQ-014 In DONE, acc, count and ovf SHALL remain stable while out_ready=0.
REQ-015 In DONE with out_ready=1, the block SHALL go to IDLE with count<=0; acc and ovf SHALL hold their values until the next first transfer.
REQ-016 out_ready outside DONE SHALL be ignored.
REQ-017 clear=1 SHALL force, on the next edge, state=IDLE, acc=0, count=0, ovf=0 and out_valid=0.
REQ-018 clear SHALL take priority over a simultaneous transfer or out_ready; the sample offered in that cycle is dropped.
REQ-019 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-020 rst=1 SHALL immediately force state=IDLE, acc=0, count=0, ovf=0, out_valid=0 and in_ready=1, in any state, including mid-batch.
REQ-021 The first transfer SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-022 Package adder4_pkg SHALL hold:
- the state enumeration (IDLE, ACCUM, DONE);
- constant SAMPLE_W=5;
- constant COUNT_W=4.
REQ-023 One sub-module, adder4_accum_cnt, SHALL implement the batch counter (load 1, increment, clear, terminal-count compare).
REQ-024 The accumulator add SHALL be behavioural ACC_W-bit arithmetic with carry-out for ovf.

Verification
REQ-025 The bench SHALL cover, with N_SAMPLES=4 and ACC_W=8 unless stated:
- Basic batch: samples {0,3},{1,15},{0,0},{0,5} on consecutive cycles -> acc=39, count=4, ovf=0, out_valid=1 on the cycle after the 4th transfer.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> out_valid, acc=39 and in_ready=0 stable, no sample accepted. Then out_ready=1 -> IDLE next cycle, count=0.
- Overflow, ACC_W=6: four samples of 31 -> acc=124 mod 64=60, ovf=1. A following batch of 1,1,1,1 -> acc=4, ovf=0.
- Gaps: the same four samples as the basic batch, with 0-3 idle cycles between each -> acc=39, count steps 1..4 only on transfers.
- Clear: clear=1 together with in_valid=1 after 2 samples -> next cycle IDLE, acc=0, count=0, the offered sample dropped.
- Reset mid-batch: rst asserted between edges after 3 samples -> outputs zero without waiting for a clock edge, in_ready=1. A batch after release completes normally.
